lstm_act_unit: RTL and testbench
================================

# lstm_act_unit

Pipelined activation unit for the LSTM datapath. It directly consumes the sigmoid and tanh tables held in the memory block: both 16-entry tables are loaded through a write port, then streamed gate pre-activations are mapped through the selected function with linear interpolation between table entries. The result stream feeds the cell/hidden-state update logic through a valid/ready handshake.

## Interface
- DATA_WIDTH, 32, sample and table-entry width; signed fixed point.
- FRAC_BITS, 16, fractional bits of input, output and table entries; must be ≥ 2.
- TAG_WIDTH, 4, width of the opaque tag carried alongside each sample.
- Table depth is fixed at 16 entries per function.

- clk  in  1  clock; all state is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- lut_wr_en  in  1  table write strobe.
- lut_wr_sel  in  1  0 = sigmoid table, 1 = tanh table.
- lut_wr_addr  in  4  table entry index.
- lut_wr_data  in  DATA_WIDTH  entry value.
- in_valid  in  1  input sample valid.
- in_ready  out  1  unit accepts a sample this cycle.
- in_data  in  DATA_WIDTH  pre-activation x, signed Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS.
- in_func  in  1  0 = sigmoid, 1 = tanh.
- in_tag  in  TAG_WIDTH  passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_WIDTH  f(x), same format as in_data.
- out_func  out  1  echo of in_func.
- out_tag  out  TAG_WIDTH  echo of in_tag.

## Operation
- Table contents: entry i of each table holds f(-4 + 0.5·i). Tables are not cleared by rst.
- Saturation: ONE = 1 << FRAC_BITS.
  - x < -4.0 (signed compare): output is 0 for sigmoid and -ONE for tanh.
  - x ≥ +4.0: output is ONE for both functions.
- In range: u = x + (4 << FRAC_BITS), so u is in [0, 8.0).
  - idx = u[FRAC_BITS+2 : FRAC_BITS-1] (4 bits).
  - frac = u[FRAC_BITS-2 : 0] (FRAC_BITS-1 bits, unsigned weight in [0, 1)).
- Interpolation:
  - lo = T[idx]; hi = T[idx+1], or ONE when idx = 15.
  - y = lo + ((hi - lo) · frac) >>> (FRAC_BITS-1).
  - The difference is signed and DATA_WIDTH+1 bits. The product is full-width with no truncation before the shift. The shift is arithmetic, rounding toward -∞.
  - The final sum is truncated to DATA_WIDTH bits.
- Pipeline stages:
  - S1: saturation flags, idx/frac, and table reads of lo and hi.
  - S2: difference and multiply.
  - S3: add and saturation mux, registered onto out_*.
  - Each stage has its own valid bit; func and tag travel with the sample.
- Flow control:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, all stage registers, including bubbles, hold.
  - A sample is accepted on in_valid & in_ready.
- Table writes:
  - A write is accepted every cycle it is strobed, regardless of pipeline state.
  - If S1 reads the entry being written in the same cycle, it uses the old value.
  - Samples already past S1 are unaffected by later writes.

## Timing
- Latency: a sample accepted at edge n appears on out_* after edge n+3 when no stall occurs.
- Throughput: 1 sample/cycle sustained with out_ready held high.
- out_* hold stable while out_valid & ~out_ready; no sample is dropped or duplicated.
- A write at edge n is visible to a sample entering S1 at edge n+1 or later.
- Reset (asynchronous, any time including mid-stream):
  - All stage valids clear.
  - out_valid=0, out_data=0, out_func=0, out_tag=0.
  - in_ready=1 once rst deasserts.
  - In-flight samples are discarded.
  - Table contents are retained.

## Test plan
- Ramp tables (T[i] = i<<16 in both), FRAC_BITS=16:
  - x=0x00000000 → 0x00080000.
  - x=0x00004000 (0.25) → 0x00088000 (8.5).
  - Each result appears exactly 3 cycles after acceptance.
- idx=15 edge: ramp table, x=0x0003C000 (3.75) → 15.0 + (1.0-15.0)·0.5 = 0x00080000.
- Saturation:
  - x=0xFFFB0000 (-5.0): sigmoid → 0x00000000, tanh → 0xFFFF0000.
  - x=0x00040000 (4.0) → 0x00010000 for both functions.
  - x=0xFFFC0000 (-4.0 exactly) → T[0].
- Backpressure:
  - Stream 8 samples with tags 0..7 and out_ready toggling randomly.
  - Every tag emerges exactly once, in order, with the correct value.
  - out_* stay stable during stalls, and in_ready=0 whenever out_valid & ~out_ready.
- Write hazard:
  - Write T_sig[8]=0x00020000 in the same cycle a sample x=0 enters S1 → that sample yields the old T[8].
  - The next sample yields 0x00020000.
- Mid-stream reset:
  - Assert rst with 3 samples in flight → out_valid drops immediately and out_data=0.
  - After release, a new sample returns correct results using the previously loaded tables.

Source files
------------

// File: rtl/lstm_act_unit.sv
// LSTM activation unit: table-driven sigmoid/tanh with linear interpolation.
// Ports: lut_wr_* table load, in_* sample stream, out_* result stream (valid/ready).
module lstm_act_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lut_wr_en,
  input  logic                  lut_wr_sel,
  input  logic [3:0]            lut_wr_addr,
  input  logic [DATA_WIDTH-1:0] lut_wr_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_func,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_func,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int DW = DATA_WIDTH;
  localparam int FB = FRAC_BITS;
  localparam int PW = DW + 1 + FB;

  localparam logic signed [DW-1:0] ONE     = DW'(1) << FB;
  localparam logic signed [DW-1:0] NEG_ONE = -ONE;
  localparam logic signed [DW-1:0] POS4    = DW'(4) << FB;
  localparam logic signed [DW-1:0] NEG4    = -POS4;

  logic [DW-1:0] sig_tbl  [16];
  logic [DW-1:0] tanh_tbl [16];

  always_ff @(posedge clk) begin
    if (lut_wr_en) begin
      if (lut_wr_sel) tanh_tbl[lut_wr_addr] <= lut_wr_data;
      else            sig_tbl[lut_wr_addr]  <= lut_wr_data;
    end
  end

  logic stall;
  logic acc;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign acc      = in_valid & in_ready;

  // input capture
  logic                 v0;
  logic [DW-1:0]        x0;
  logic                 f0;
  logic [TAG_WIDTH-1:0] t0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      x0 <= '0;
      f0 <= 1'b0;
      t0 <= '0;
    end else if (!stall) begin
      v0 <= acc;
      x0 <= in_data;
      f0 <= in_func;
      t0 <= in_tag;
    end
  end

  // S1: range flags, index/fraction, table reads
  logic          sl_c;
  logic          sh_c;
  logic [FB+2:0] u_c;
  logic [3:0]    idx_c;
  logic [3:0]    idx_p1;
  logic [FB-2:0] frac_c;
  logic [DW-1:0] lo_c;
  logic [DW-1:0] hi_c;

  // Only the low FB+3 bits of x + 4.0 matter for an in-range x.
  assign sl_c   = $signed(x0) < NEG4;
  assign sh_c   = $signed(x0) >= POS4;
  assign u_c    = {x0[FB+2:FB] + 3'b100, x0[FB-1:0]};
  assign idx_c  = u_c[FB+2:FB-1];
  assign idx_p1 = idx_c + 4'd1;
  assign frac_c = u_c[FB-2:0];
  assign lo_c   = f0 ? tanh_tbl[idx_c] : sig_tbl[idx_c];
  assign hi_c   = (idx_c == 4'd15) ? ONE
                : (f0 ? tanh_tbl[idx_p1] : sig_tbl[idx_p1]);

  logic                 v1;
  logic                 f1;
  logic [TAG_WIDTH-1:0] t1;
  logic                 sl1;
  logic                 sh1;
  logic [DW-1:0]        lo1;
  logic [DW-1:0]        hi1;
  logic [FB-2:0]        frac1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      f1    <= 1'b0;
      t1    <= '0;
      sl1   <= 1'b0;
      sh1   <= 1'b0;
      lo1   <= '0;
      hi1   <= '0;
      frac1 <= '0;
    end else if (!stall) begin
      v1    <= v0;
      f1    <= f0;
      t1    <= t0;
      sl1   <= sl_c;
      sh1   <= sh_c;
      lo1   <= lo_c;
      hi1   <= hi_c;
      frac1 <= frac_c;
    end
  end

  // S2: signed difference times unsigned fraction
  logic signed [DW:0]   diff_c;
  logic signed [PW-1:0] prod_c;
  logic                 unused_prod;

  assign diff_c = $signed({hi1[DW-1], hi1}) - $signed({lo1[DW-1], lo1});
  assign prod_c = $signed({{FB{diff_c[DW]}}, diff_c})
                * $signed({{(DW+2){1'b0}}, frac1});

  // Taking this slice is the arithmetic shift right by FB-1,
  // truncated to DW bits.
  assign unused_prod = ^{prod_c[FB-2:0], prod_c[PW-1:DW+FB-1]};

  logic                 v2;
  logic                 f2;
  logic [TAG_WIDTH-1:0] t2;
  logic                 sl2;
  logic                 sh2;
  logic [DW-1:0]        lo2;
  logic [DW-1:0]        p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      f2  <= 1'b0;
      t2  <= '0;
      sl2 <= 1'b0;
      sh2 <= 1'b0;
      lo2 <= '0;
      p2  <= '0;
    end else if (!stall) begin
      v2  <= v1;
      f2  <= f1;
      t2  <= t1;
      sl2 <= sl1;
      sh2 <= sh1;
      lo2 <= lo1;
      p2  <= prod_c[FB-1 +: DW];
    end
  end

  // S3: add and saturation select
  logic [DW-1:0] res_c;

  always_comb begin
    res_c = lo2 + p2;
    unique case (1'b1)
      sh2:     res_c = ONE;
      sl2:     res_c = f2 ? NEG_ONE : '0;
      default: res_c = lo2 + p2;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_func  <= 1'b0;
      out_tag   <= '0;
    end else if (!stall) begin
      out_valid <= v2;
      out_data  <= res_c;
      out_func  <= f2;
      out_tag   <= t2;
    end
  end

endmodule

// File: tb/tb_lstm_act_unit.sv
// Directed testbench for lstm_act_unit.
// Scoreboard of hand-computed results, checked on the falling edge.
module tb_lstm_act_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lut_wr_en = 1'b0;
  logic        lut_wr_sel = 1'b0;
  logic [3:0]  lut_wr_addr = '0;
  logic [31:0] lut_wr_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_func = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_func;
  logic [3:0]  out_tag;

  lstm_act_unit dut (
    .clk         (clk),
    .rst         (rst),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_sel  (lut_wr_sel),
    .lut_wr_addr (lut_wr_addr),
    .lut_wr_data (lut_wr_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_func     (in_func),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_func    (out_func),
    .out_tag     (out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic        f;
    int          e;
  } exp_t;

  exp_t exp_q[$];
  bit   lat_chk = 1'b0;
  bit   bp_on = 1'b0;
  bit   prev_stall = 1'b0;
  logic [31:0] hold_d;
  logic [3:0]  hold_t;

  // result monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", 32'(out_valid), 32'd1);
        check("hold_data", out_data, hold_d);
        check("hold_tag", 32'(out_tag), 32'(hold_t));
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) begin
        check("stall_rdy", 32'(in_ready), 32'd0);
        hold_d = out_data;
        hold_t = out_tag;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious", 32'(out_tag), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("data", out_data, e.d);
          check("tag", 32'(out_tag), 32'(e.t));
          check("func", 32'(out_func), 32'(e.f));
          if (lat_chk) check("latency", 32'(cyc - e.e), 32'd3);
        end
      end
    end
  end

  // call at posedge+#1; returns at posedge+#1 after acceptance
  task automatic send(input logic [31:0] x, input logic f,
                      input logic [3:0] tag, input logic [31:0] exp);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    in_data  = x;
    in_func  = f;
    in_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e.d = exp;
      e.t = tag;
      e.f = f;
      e.e = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic lut_wr(input logic sel, input logic [3:0] addr,
                        input logic [31:0] data);
    lut_wr_en   = 1'b1;
    lut_wr_sel  = sel;
    lut_wr_addr = addr;
    lut_wr_data = data;
    @(posedge clk);
    #1;
    lut_wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vx [10];
  logic        vf [10];
  logic [31:0] ve [10];

  initial begin
    vx[0] = 32'h0000_0000; vf[0] = 0; ve[0] = 32'h0008_0000;
    vx[1] = 32'h0000_4000; vf[1] = 0; ve[1] = 32'h0008_8000;
    vx[2] = 32'h0003_C000; vf[2] = 1; ve[2] = 32'h0008_0000;
    vx[3] = 32'hFFFB_0000; vf[3] = 0; ve[3] = 32'h0000_0000;
    vx[4] = 32'hFFFB_0000; vf[4] = 1; ve[4] = 32'hFFFF_0000;
    vx[5] = 32'h0004_0000; vf[5] = 0; ve[5] = 32'h0001_0000;
    vx[6] = 32'hFFFC_0000; vf[6] = 1; ve[6] = 32'h0000_0000;
    vx[7] = 32'hFFFE_4000; vf[7] = 0; ve[7] = 32'h0004_8000;
    vx[8] = 32'h0004_0000; vf[8] = 1; ve[8] = 32'h0001_0000;
    vx[9] = 32'hFFFC_0000; vf[9] = 0; ve[9] = 32'h0000_0000;

    #12;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    check("rst_func", 32'(out_func), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rdy_after_rst", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++) lut_wr(1'b0, 4'(i), 32'(i) << 16);
    for (int i = 0; i < 16; i++) lut_wr(1'b1, 4'(i), 32'(i) << 16);

    // directed vectors, out_ready high, latency checked
    lat_chk = 1'b1;
    for (int i = 0; i < 10; i++) send(vx[i], vf[i], 4'(i), ve[i]);
    drain();
    lat_chk = 1'b0;

    // random backpressure
    bp_on = 1'b1;
    fork
      begin
        while (bp_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 8; i++) send(vx[i], vf[i], 4'(i), ve[i]);
    drain();
    bp_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // table write racing the S1 read of the same entry
    send(32'h0, 1'b0, 4'd10, 32'h0008_0000);
    lut_wr_en   = 1'b1;
    lut_wr_sel  = 1'b0;
    lut_wr_addr = 4'd8;
    lut_wr_data = 32'h0002_0000;
    send(32'h0, 1'b0, 4'd11, 32'h0002_0000);
    lut_wr_en = 1'b0;
    drain();

    // reset with three samples in flight
    send(32'h0000_4000, 1'b1, 4'd12, 32'h0008_8000);
    send(32'h0003_C000, 1'b1, 4'd13, 32'h0008_0000);
    send(32'h0004_0000, 1'b0, 4'd14, 32'h0001_0000);
    @(posedge clk);
    #2;
    check("pre_rst_vld", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_vld", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_tag", 32'(out_tag), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rdy_post_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(32'h0, 1'b0, 4'd15, 32'h0002_0000);
    send(32'h0000_4000, 1'b1, 4'd1, 32'h0008_8000);
    drain();
    lat_chk = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", exp_q.size());
    $fatal(1, "timeout");
  end

endmodule
